md_stim_driver: RTL

//   Synthesizable stimulus transmitter and checker for the Magical Dartboard (MD) interface.
//   - Generates one MD pattern from a 16-bit LFSR: 16 board scores on in_valid_1, then
//     NUM_DARTS dart/rotation beats on in_valid_2.
//   - Computes the golden sum internally, captures the out_valid/out_sum response and

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_stim_driver_if.sv | 26 ++
 rtl/md_lfsr.sv | 32 +++
 rtl/md_stim_driver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the Magical Dartboard stimulus driver.
// FSM states, ring bases, LFSR polynomial and the LFSR step helper.
package md_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCORE,
        ST_GAP,
        ST_DART,
        ST_WAIT
    } md_state_e;

    localparam logic [3:0]  INNER_BASE   = 4'd0;
    localparam logic [3:0]  OUTER_BASE   = 4'd8;
    localparam int          SCORE_BEATS  = 16;
    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] r;
        r = {1'b0, s[15:1]};
        if (s[0])
            r = r ^ LFSR_POLY;
        return r;
    endfunction

endpackage

// File: rtl/md_stim_driver_if.sv
// MD stimulus/response bundle between the driver and the dartboard.
// master = stimulus driver, slave = dartboard under test.
interface md_stim_driver_if;

    logic       in_valid_1;
    logic [2:0] in_score;
    logic       in_valid_2;
    logic [3:0] in_dart;
    logic [2:0] in_rotation;
    logic       rotate_flag;
    logic       out_valid;
    logic [6:0] out_sum;

    modport master (
        output in_valid_1, in_score,
        output in_valid_2, in_dart, in_rotation, rotate_flag,
        input  out_valid, out_sum
    );

    modport slave (
        input  in_valid_1, in_score,
        input  in_valid_2, in_dart, in_rotation, rotate_flag,
        output out_valid, out_sum
    );

endinterface

// File: rtl/md_lfsr.sv
// 16-bit Galois LFSR with seed load and advance enable.
// A zero seed is replaced by LFSR_DEFAULT so the sequence never locks up.
module md_lfsr
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] state,
    output logic [15:0] state_nxt
);

    // Next value: load wins over advance, otherwise hold
    always_comb begin
        state_nxt = state;
        if (load)
            state_nxt = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
        else if (adv)
            state_nxt = lfsr_step(state);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LFSR_DEFAULT;
        else
            state <= state_nxt;
    end

endmodule

// File: rtl/md_stim_driver.sv
// MD stimulus transmitter and response checker.
// Optional macro MD_DRV_TIMEOUT_EN enables the WAIT_OUT response timeout.
module md_stim_driver
    import md_pkg::*;
#(
    parameter int NUM_DARTS = 8,
    parameter int GAP_CYC   = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       seed,
    md_stim_driver_if.master  md,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [6:0]        exp_sum
);

    localparam int CNT_W = $clog2(TIMEOUT + SCORE_BEATS + NUM_DARTS + GAP_CYC + 1);

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ld, adv, done_nxt, pass_set, fail_set;
    logic [15:0]      lfsr, lfsr_nxt;
    logic [2:0]       board [SCORE_BEATS];
    logic [3:0]       pi, po, pi_nxt, po_nxt, ring, slot;
    logic [2:0]       step;
    logic             unused_bits;
`ifdef MD_DRV_TIMEOUT_EN
    logic             to_set;
`endif

    assign unused_bits = ^{lfsr[15:8], lfsr_nxt[15:8]};

    md_lfsr u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load      (ld),
        .adv       (adv),
        .seed      (seed),
        .state     (lfsr),
        .state_nxt (lfsr_nxt)
    );

    // State and beat counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, verdict and LFSR control
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        ld        = 1'b0;
        adv       = 1'b0;
        done_nxt  = 1'b0;
        pass_set  = 1'b0;
        fail_set  = 1'b0;
`ifdef MD_DRV_TIMEOUT_EN
        to_set    = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    ld        = 1'b1;
                    state_nxt = ST_SCORE;
                end
            end
            ST_SCORE: begin
                adv = 1'b1;
                if (md.out_valid) begin
                    fail_set  = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_W'(SCORE_BEATS - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (md.out_valid) begin
                    fail_set  = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_DART;
                end
            end
            ST_DART: begin
                adv = 1'b1;
                if (md.out_valid) begin
                    fail_set  = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_W'(NUM_DARTS - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (md.out_valid) begin
                    pass_set  = (md.out_sum == exp_sum);
                    fail_set  = (md.out_sum != exp_sum);
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
`ifdef MD_DRV_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    to_set    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Golden model: score the dart, then rotate or swap the rings
    always_comb begin
        ring   = lfsr[3] ? po : pi;
        slot   = {ring[3], ring[2:0] + lfsr[2:0]};
        step   = lfsr[6:4];
        pi_nxt = pi;
        po_nxt = po;
        if (step == 3'd0) begin
            pi_nxt = po;
            po_nxt = pi;
        end else if (lfsr[7]) begin
            pi_nxt = {pi[3], pi[2:0] + step};
        end else begin
            pi_nxt = {pi[3], pi[2:0] - step};
        end
    end

    // Registered stimulus, status, board file and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md.in_valid_1  <= 1'b0;
            md.in_score    <= '0;
            md.in_valid_2  <= 1'b0;
            md.in_dart     <= '0;
            md.in_rotation <= '0;
            md.rotate_flag <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            exp_sum        <= '0;
            pi             <= '0;
            po             <= '0;
            for (int i = 0; i < SCORE_BEATS; i++)
                board[i] <= '0;
        end else begin
            md.in_valid_1  <= (state_nxt == ST_SCORE);
            md.in_score    <= (state_nxt == ST_SCORE) ? lfsr_nxt[2:0] : 3'd0;
            md.in_valid_2  <= (state_nxt == ST_DART);
            md.in_dart     <= (state_nxt == ST_DART) ? lfsr_nxt[3:0] : 4'd0;
            md.in_rotation <= (state_nxt == ST_DART) ? lfsr_nxt[6:4] : 3'd0;
            md.rotate_flag <= (state_nxt == ST_DART) && lfsr_nxt[7];
            busy           <= (state_nxt != ST_IDLE);
            done           <= done_nxt;
            if (ld) begin
                pass    <= 1'b0;
                fail    <= 1'b0;
                exp_sum <= '0;
                pi      <= INNER_BASE;
                po      <= OUTER_BASE;
            end
            if (pass_set)
                pass <= 1'b1;
            if (fail_set)
                fail <= 1'b1;
            if (state == ST_SCORE)
                board[cnt[3:0]] <= lfsr[2:0];
            if (state == ST_DART) begin
                exp_sum <= exp_sum + {4'd0, board[slot]};
                pi      <= pi_nxt;
                po      <= po_nxt;
            end
        end
    end

`ifdef MD_DRV_TIMEOUT_EN
    // Sticky timeout flag, cleared by the next start
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout <= 1'b0;
        else if (ld)
            timeout <= 1'b0;
        else if (to_set)
            timeout <= 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
